// File: rtl/risc_pkg.sv
// Shared types for the memory arbiter: access size, arbiter state, owner and
// the registered memory command payload.
package risc_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic            wr_en;
    mem_size_t       size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Cycle counter for the WAIT state; expired_c flags the TIMEOUT-th enabled cycle.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Count starts at zero on the first enabled cycle, so TIMEOUT-1 marks the last one.
  assign expired_c = en && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single memory port, one transaction
// outstanding, with data-streak limiting and a WAIT-state timeout.
module mem_arbiter
  import risc_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_wr_en,
  input  mem_size_t   d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_wr_en,
  output mem_size_t   m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

  arb_state_t    state, state_nxt;
  arb_owner_t    owner, owner_nxt;
  logic [SW-1:0] dstreak, dstreak_nxt;
  mem_cmd_t      cmd, cmd_nxt;
  logic          m_req_nxt;
  logic          wd_clr_c, wd_en_c, wd_expired_c;
  logic          resp_c, resp_err_c;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (wd_expired_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    dstreak_nxt = dstreak;
    cmd_nxt     = cmd;
    m_req_nxt   = 1'b0;
    wd_clr_c    = 1'b0;
    wd_en_c     = 1'b0;
    resp_c      = 1'b0;
    resp_err_c  = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          // Data has priority until it has won MAX_DSTREAK times over a waiting fetch.
          if (d_req && !(i_req && dstreak == SW'(MAX_DSTREAK))) begin
            owner_nxt   = OWNER_D;
            cmd_nxt     = '{wr_en: d_wr_en, size: d_size, addr: d_addr, wdata: d_wdata};
            dstreak_nxt = (dstreak == SW'(MAX_DSTREAK)) ? dstreak : dstreak + SW'(1);
          end else begin
            owner_nxt   = OWNER_I;
            cmd_nxt     = '{wr_en: 1'b0, size: MEM_SIZE_WORD, addr: i_addr, wdata: 32'h0};
            dstreak_nxt = '0;
          end
          m_req_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          wd_clr_c  = 1'b1;
          state_nxt = WAIT;
        end else begin
          m_req_nxt = 1'b1;
        end
      end
      WAIT: begin
        wd_en_c = 1'b1;
        if (m_rvalid) begin
          resp_c    = 1'b1;
          state_nxt = RESP;
        end else if (wd_expired_c) begin
          resp_c     = 1'b1;
          resp_err_c = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner   <= OWNER_I;
      dstreak <= '0;
      cmd     <= '0;
      m_req   <= 1'b0;
      i_valid <= 1'b0;
      i_rdata <= 32'h0;
      i_err   <= 1'b0;
      d_valid <= 1'b0;
      d_rdata <= 32'h0;
      d_err   <= 1'b0;
    end else begin
      owner   <= owner_nxt;
      dstreak <= dstreak_nxt;
      cmd     <= cmd_nxt;
      m_req   <= m_req_nxt;
      i_valid <= resp_c && (owner == OWNER_I);
      d_valid <= resp_c && (owner == OWNER_D);
      if (resp_c && owner == OWNER_I) begin
        i_rdata <= resp_err_c ? 32'h0 : m_rdata;
        i_err   <= resp_err_c;
      end
      if (resp_c && owner == OWNER_D) begin
        d_rdata <= resp_err_c ? 32'h0 : m_rdata;
        d_err   <= resp_err_c;
      end
    end
  end

  assign m_wr_en = cmd.wr_en;
  assign m_size  = cmd.size;
  assign m_addr  = cmd.addr;
  assign m_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, arbitration
// order, randomized traffic against a request-level model, and mid-flight reset.
module tb_mem_arbiter;
  import risc_pkg::*;

  localparam int unsigned MAXD = 4;
  localparam int unsigned TMO  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_wr_en, m_ready, m_rvalid;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  mem_size_t   d_size;
  logic        i_valid, i_err, d_valid, d_err, m_req, m_wr_en;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  mem_size_t   m_size;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wr_en(d_wr_en), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_wr_en(m_wr_en), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic        wr;
    mem_size_t   size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_dly;
    int          rvalid_dly;
    logic        exp_wr;
    mem_size_t   exp_size;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wait;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plays the memory side for one transaction while scrambling requester inputs.
  task automatic serve(input int ready_dly, input int rvalid_dly, input logic [31:0] rdata,
                       output mem_cmd_t seen, output int issue_lat, output bit stable,
                       output logic vi, output logic vd, output logic [31:0] rd,
                       output logic er, output int wait_cyc);
    logic [31:0] sv_ia, sv_da, sv_dw;
    logic        sv_wr;
    mem_size_t   sv_sz;
    issue_lat = 0;
    do begin
      @(negedge clk);
      issue_lat++;
    end while (!m_req && issue_lat < 50);
    seen = '{wr_en: m_wr_en, size: m_size, addr: m_addr, wdata: m_wdata};
    sv_ia = i_addr; sv_da = d_addr; sv_dw = d_wdata; sv_wr = d_wr_en; sv_sz = d_size;
    i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_wr_en = ~sv_wr;
    d_size = (sv_sz == MEM_SIZE_BYTE) ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
    stable = 1'b1;
    for (int k = 0; k < ready_dly; k++) begin
      m_ready  = 1'b0;
      m_rvalid = (k == 0);
      m_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      m_rvalid = 1'b0;
      if ({m_req, m_wr_en, m_size, m_addr, m_wdata} !== {1'b1, seen}) stable = 1'b0;
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    if (rvalid_dly >= 0) begin
      repeat (rvalid_dly) @(negedge clk);
      m_rvalid = 1'b1;
      m_rdata  = rdata;
      @(negedge clk);
      m_rvalid = 1'b0;
    end
    wait_cyc = 0;
    while (!(i_valid || d_valid) && wait_cyc < 400) begin
      @(negedge clk);
      wait_cyc++;
    end
    vi = i_valid;
    vd = d_valid;
    rd = d_valid ? d_rdata : i_rdata;
    er = d_valid ? d_err : i_err;
    i_addr = sv_ia; d_addr = sv_da; d_wdata = sv_dw; d_wr_en = sv_wr; d_size = sv_sz;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mem_cmd_t    seen, exp_cmd, exp_d_cmd;
    int          lat, wcyc, streak, rdly;
    bit          stab, wd, i_pend, d_pend, quiet;
    logic        vi, vd, er;
    logic [31:0] rd, rdat, exp_i_addr;

    vecs[0] = '{1, 1'b0, MEM_SIZE_WORD, 32'h100,  32'h0,        32'hCAFEF00D, 0,  0,
                1'b0, MEM_SIZE_WORD, 32'h0,        32'hCAFEF00D, 1'b0, 0};
    vecs[1] = '{1, 1'b1, MEM_SIZE_WORD, 32'h40,   32'h12345678, 32'h0,        3,  1,
                1'b1, MEM_SIZE_WORD, 32'h12345678, 32'h0,        1'b0, 0};
    vecs[2] = '{0, 1'b1, MEM_SIZE_BYTE, 32'h200,  32'h5555AAAA, 32'h13,       0,  2,
                1'b0, MEM_SIZE_WORD, 32'h0,        32'h13,       1'b0, 0};
    vecs[3] = '{0, 1'b0, MEM_SIZE_WORD, 32'h300,  32'h0,        32'hFFFFFFFF, 1, -1,
                1'b0, MEM_SIZE_WORD, 32'h0,        32'h0,        1'b1, 8};
    vecs[4] = '{1, 1'b0, MEM_SIZE_BYTE, 32'h123,  32'h0,        32'hAB,       1,  4,
                1'b0, MEM_SIZE_BYTE, 32'h0,        32'hAB,       1'b0, 0};
    vecs[5] = '{1, 1'b1, MEM_SIZE_HALF, 32'h2222, 32'hBEEF,     32'h0,        2,  0,
                1'b1, MEM_SIZE_HALF, 32'hBEEF,     32'h0,        1'b0, 0};

    reset_n = 1'b0;
    i_req = 0; d_req = 0; d_wr_en = 0; m_ready = 0; m_rvalid = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_size = MEM_SIZE_BYTE;
    repeat (3) @(negedge clk);
    chk("reset_outputs", |{m_req, m_wr_en, m_size, m_addr, m_wdata,
                           i_valid, i_rdata, i_err, d_valid, d_rdata, d_err}, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed vectors, each started from IDLE
    foreach (vecs[v]) begin
      d_wr_en = vecs[v].wr; d_size = vecs[v].size; d_wdata = vecs[v].wdata;
      if (vecs[v].is_d) begin
        d_req = 1'b1; d_addr = vecs[v].addr;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr; d_addr = 32'hDEAD0000;
      end
      serve(vecs[v].ready_dly, vecs[v].rvalid_dly, vecs[v].rdata, seen, lat, stab, vi, vd, rd, er, wcyc);
      exp_cmd = '{wr_en: vecs[v].exp_wr, size: vecs[v].exp_size, addr: vecs[v].addr,
                  wdata: vecs[v].exp_wdata};
      chk($sformatf("v%0d_issue_latency", v), lat, 1);
      chk($sformatf("v%0d_cmd_fields", v), seen, exp_cmd);
      chk($sformatf("v%0d_fields_stable", v), stab, 1'b1);
      chk($sformatf("v%0d_valid_side", v), {vi, vd}, {~vecs[v].is_d, vecs[v].is_d});
      chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
      chk($sformatf("v%0d_err", v), er, vecs[v].exp_err);
      chk($sformatf("v%0d_wait_cycles", v), wcyc, vecs[v].exp_wait);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_valid_one_cycle", v), {i_valid, d_valid}, 2'b00);
    end

    // Both sides held: streak limit decides the grant order
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_addr = 32'h2000; d_wr_en = 1'b0; d_size = MEM_SIZE_WORD; d_wdata = 32'h0;
    streak = 0;
    for (int n = 0; n < 10; n++) begin
      wd = (streak != int'(MAXD));
      serve(0, 0, $urandom, seen, lat, stab, vi, vd, rd, er, wcyc);
      chk($sformatf("arb_grant%0d", n), {vi, vd}, {~wd, wd});
      chk($sformatf("arb_addr%0d", n), seen.addr, wd ? 32'h2000 : 32'h1000);
      streak = wd ? ((streak < int'(MAXD)) ? streak + 1 : streak) : 0;
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized traffic against a request-level model
    streak = 0; i_pend = 0; d_pend = 0;
    for (int n = 0; n < 40; n++) begin
      if (!d_pend && ($urandom % 2 == 0)) d_pend = 1;
      if (!i_pend && ($urandom % 2 == 0)) i_pend = 1;
      if (!d_pend && !i_pend) begin
        if ($urandom % 2 == 0) d_pend = 1; else i_pend = 1;
      end
      if (d_pend && !d_req) begin
        d_req = 1'b1; d_wr_en = 1'($urandom); d_size = mem_size_t'(2'($urandom % 3));
        d_addr = $urandom; d_wdata = $urandom;
        exp_d_cmd = '{wr_en: d_wr_en, size: d_size, addr: d_addr, wdata: d_wdata};
      end
      if (i_pend && !i_req) begin
        i_req = 1'b1; i_addr = $urandom; exp_i_addr = i_addr;
      end
      wd = d_pend && !(i_pend && streak == int'(MAXD));
      exp_cmd = wd ? exp_d_cmd : '{wr_en: 1'b0, size: MEM_SIZE_WORD, addr: exp_i_addr, wdata: 32'h0};
      rdly = ($urandom % 8 == 0) ? -1 : int'($urandom % 5);
      rdat = $urandom;
      serve(int'($urandom % 4), rdly, rdat, seen, lat, stab, vi, vd, rd, er, wcyc);
      chk($sformatf("rnd%0d_owner", n), {vi, vd}, {~wd, wd});
      chk($sformatf("rnd%0d_cmd", n), seen, exp_cmd);
      chk($sformatf("rnd%0d_stable", n), stab, 1'b1);
      chk($sformatf("rnd%0d_rdata", n), rd, (rdly < 0) ? 32'h0 : rdat);
      chk($sformatf("rnd%0d_err", n), er, rdly < 0);
      if (wd) begin
        streak = (streak < int'(MAXD)) ? streak + 1 : streak;
        d_req = 1'b0; d_pend = 0;
      end else begin
        streak = 0;
        i_req = 1'b0; i_pend = 0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset while waiting on memory aborts the fetch
    i_req = 1'b1; i_addr = 32'h500;
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    i_req   = 1'b0;
    #1;
    chk("midreset_outputs", |{m_req, m_wr_en, m_size, m_addr, m_wdata,
                              i_valid, i_rdata, i_err, d_valid, d_rdata, d_err}, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
    @(negedge clk);
    m_rvalid = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (i_valid || d_valid || m_req) quiet = 1'b0;
      @(negedge clk);
    end
    chk("late_rvalid_ignored", quiet, 1'b1);
    d_req = 1'b1; d_wr_en = 1'b0; d_size = MEM_SIZE_WORD; d_addr = 32'h600;
    serve(0, 0, 32'h0BADF00D, seen, lat, stab, vi, vd, rd, er, wcyc);
    chk("post_reset_latency", lat, 1);
    chk("post_reset_side", {vi, vd}, 2'b01);
    chk("post_reset_rdata", rd, 32'h0BADF00D);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DSTREAK, default 4, maximum consecutive data grants while instruction request pending.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles in WAIT before forced error response.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_req  in  1  instruction fetch request, level, held until i_valid.
REQ-006 i_addr  in  32  fetch address.
REQ-007 i_valid  out  1  one-cycle response pulse to fetch side.
REQ-008 i_rdata  out  32  fetch read data, meaningful while i_valid.
REQ-009 i_err  out  1  fetch response is timeout error, qualified by i_valid.
REQ-010 d_req  in  1  data request, level, held until d_valid.
REQ-011 d_wr_en  in  1  data write (1) / read (0).
REQ-012 d_size  in  mem_size_t  access size.
REQ-013 d_addr  in  32  data address.
REQ-014 d_wdata  in  32  write data.
REQ-015 d_valid  out  1  one-cycle response pulse to data side (read data or write ack).
REQ-016 d_rdata  out  32  data read data, meaningful while d_valid and read.
REQ-017 d_err  out  1  data response is timeout error, qualified by d_valid.
REQ-018 m_req  out  1  shared memory port request.
REQ-019 m_wr_en / m_size / m_addr / m_wdata  out  1 / mem_size_t / 32 / 32  registered command fields.
REQ-020 m_ready  in  1  memory accepts command when m_req & m_ready.
REQ-021 m_rvalid  in  1  memory response (read data or write ack), one cycle.
REQ-022 m_rdata  in  32  memory read data.

Function
REQ-023 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-024 IDLE: no request -> stay; otherwise grant per REQ-028, capture owner and command fields into registers, -> ISSUE.
REQ-025 ISSUE: m_req=1; m_ready=1 -> WAIT; else stay with fields stable.
REQ-026 WAIT: m_rvalid=1 -> latch m_rdata into owner's rdata register, -> RESP; watchdog reaches TIMEOUT -> owner rdata=32'h0, err=1, -> RESP.
REQ-027 RESP: owner's valid=1 exactly one cycle, other side's valid=0, no arbitration, -> IDLE; requester drops or renews req by the next cycle.
REQ-028 Arbitration: single requester wins; both pending -> data wins unless dstreak==MAX_DSTREAK, then instruction wins.
REQ-029 dstreak: +1 (saturating at MAX_DSTREAK) per data grant, cleared per instruction grant.
REQ-030 Instruction commands drive m_wr_en=0, m_size=MEM_SIZE_WORD, m_wdata=0.
REQ-031 Requester input changes after grant do not affect m_* fields.
REQ-032 m_rvalid outside WAIT and m_ready outside ISSUE ignored.
REQ-033 Watchdog counts cycles in WAIT, clears on entering WAIT.
REQ-034 Minimum latency: req seen in IDLE cycle 0, m_req cycle 1, m_rvalid cycle 2, valid cycle 3.

Reset
REQ-035 reset_n low: state=IDLE, dstreak=0, watchdog=0, all outputs 0 (m_req, m_* fields, i/d_valid, i/d_rdata, i/d_err).
REQ-036 Reset mid-transaction aborts it; no response delivered; later m_rvalid ignored per REQ-032.

Structure
REQ-037 risc_pkg holds arb_state_t (IDLE, ISSUE, WAIT, RESP) and arb_owner_t (OWNER_I, OWNER_D); mem_size_t reused from risc_pkg.
REQ-038 One sub-module mem_arb_watchdog: counter with clear/enable inputs and expired output, parameterised by TIMEOUT.

Verification
REQ-039 Data read only, addr 0x100, m_ready=1, m_rvalid next cycle with 0xCAFEF00D -> d_valid cycle 3, d_rdata=0xCAFEF00D, i_valid=0.
REQ-040 i_req and d_req held continuously, MAX_DSTREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-041 Data write 0x12345678 to 0x40, size word, m_ready low 3 cycles -> m_* fields stable throughout, d_valid with d_err=0 after m_rvalid.
REQ-042 Fetch with m_rvalid never asserted, TIMEOUT=8 -> i_valid=1, i_err=1, i_rdata=0 after 8 WAIT cycles.
REQ-043 reset_n low during WAIT, m_rvalid after release -> no i_valid/d_valid, all outputs 0, next request served normally.
